hash_digest_collector: RTL and testbench

- Downstream stage of the serial hashing wrapper. Consumes the 1-bit serial digest stream (LSB first) and the hash-ready flag, and reassembles an L-bit parallel digest.
- Presents the digest with a valid/ack handshake to the host-side logic (UART/LED readout, result register).
- Detects truncated streams: hash-ready deasserting before L bits have arrived.

---
 rtl/hash_digest_collector.sv | 143 ++++++++++++++
 tb/tb_hash_digest_collector.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_digest_collector.sv
// hash_digest_collector
//   Reassembles the LSB-first serial digest coming out of the hashing wrapper
//   into an L-bit parallel word and hands it to the host side with a
//   valid/ack handshake. If hash-ready falls before all L bits have arrived,
//   the stream was truncated and a sticky error flag is raised.
//
//   Optional feature (macro HASH_DIGEST_CHECK_EN): adds expected_digestxSI and
//   matchxSO. When the digest completes, it is compared against an expected
//   value. When the macro is undefined, neither port nor compare exists.
module hash_digest_collector #(
  parameter int L   = 256,  // digest length in bits
  parameter int LAT = 0,    // idle cycles between ready seen and first bit (0..15)
  parameter int CW  = 9     // counter width, 2**CW > L
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hash_readyxSI,
  input  logic          hash_digestxSI,
  input  logic          digest_ackxSI,
`ifdef HASH_DIGEST_CHECK_EN
  input  logic [L-1:0]  expected_digestxSI,
  output logic          matchxSO,
`endif
  output logic [L-1:0]  digestxSO,
  output logic          digest_validxSO,
  output logic          busyxSO,
  output logic          errxSO,
  output logic [CW-1:0] bit_countxSO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_SHIFT,
    S_HOLD,
    S_WAIT_LOW
  } state_t;

  // Index width needed to address one bit of the digest.
  localparam int IW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST_BIT   = CW'(L - 1);
  localparam logic [3:0]    ALIGN_LAST = 4'((LAT > 0) ? (LAT - 1) : 0);

  state_t       state;
  logic [3:0]   align_cnt;
  logic [L-1:0] digest_next;

  // Digest with the current serial bit placed at the current count position;
  // this is what the register takes on a SHIFT edge and what the optional
  // compare sees on the final edge.
  // NOTE: always_comb assigns a full default before the partial overwrite so
  // that no bit is left unassigned on any path and no latch is inferred.
  always_comb begin
    digest_next = digestxSO;
    digest_next[bit_countxSO[IW-1:0]] = hash_digestxSI;
  end

  // Busy is a pure decode of the state: high while a stream is being taken in.
  assign busyxSO = (state == S_ALIGN) || (state == S_SHIFT);

  // Capture FSM with registered outputs.
  // NOTE: the digest register is reset along with the control state because
  // reset must clear every output at once; it is a flop vector, not a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every sequential assignment is non-blocking so all registers
      // update from the same pre-edge values, with no ordering races.
      state           <= S_IDLE;
      align_cnt       <= '0;
      digestxSO       <= '0;
      digest_validxSO <= 1'b0;
      errxSO          <= 1'b0;
      bit_countxSO    <= '0;
`ifdef HASH_DIGEST_CHECK_EN
      matchxSO        <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          // The last digest stays visible until a new stream overwrites it.
          if (hash_readyxSI) begin
            bit_countxSO <= '0;
            errxSO       <= 1'b0;
            align_cnt    <= '0;
`ifdef HASH_DIGEST_CHECK_EN
            matchxSO     <= 1'b0;
`endif
            state        <= (LAT == 0) ? S_SHIFT : S_ALIGN;
          end
        end

        S_ALIGN: begin
          // Skip the wrapper's pipeline slack before the first real bit.
          if (!hash_readyxSI) begin
            errxSO <= 1'b1;
            state  <= S_IDLE;
          end else if (align_cnt == ALIGN_LAST) begin
            state <= S_SHIFT;
          end else begin
            align_cnt <= align_cnt + 4'd1;
          end
        end

        S_SHIFT: begin
          if (!hash_readyxSI) begin
            // Truncated stream: the bit on this edge is not valid data.
            errxSO <= 1'b1;
            state  <= S_IDLE;
          end else begin
            digestxSO    <= digest_next;
            bit_countxSO <= bit_countxSO + 1'b1;
            if (bit_countxSO == LAST_BIT) begin
              digest_validxSO <= 1'b1;
`ifdef HASH_DIGEST_CHECK_EN
              matchxSO        <= (digest_next == expected_digestxSI);
`endif
              state           <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          // The wrapper may keep clocking bits out; they are ignored here.
          // Ready falling in this state is a normal end of stream.
          if (digest_ackxSI) begin
            digest_validxSO <= 1'b0;
            state           <= hash_readyxSI ? S_WAIT_LOW : S_IDLE;
          end
        end

        S_WAIT_LOW: begin
          // A still-high ready belongs to the stream just delivered.
          if (!hash_readyxSI) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_digest_collector.sv
// Self-checking bench for hash_digest_collector with L=8. Two instances run
// side by side: index 0 with LAT=0 and index 1 with LAT=2. Streams are
// described at transaction level (data byte, truncation point, release style).
// The expected digest is kept per instance as the byte the host should see.
`timescale 1ns/1ps
module tb_hash_digest_collector;

  localparam int L  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          ready   [2];
  logic          dbit    [2];
  logic          ack     [2];
  logic [L-1:0]  digest  [2];
  logic          valid   [2];
  logic          busy    [2];
  logic          err     [2];
  logic [CW-1:0] cnt     [2];
`ifdef HASH_DIGEST_CHECK_EN
  logic [L-1:0]  expd    [2];
  logic          match   [2];
`endif

  // Model state: the digest each instance should currently present.
  logic [L-1:0] exp_dig [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hash_digest_collector #(.L(L), .LAT(0), .CW(CW)) u_lat0 (
    .clk                (clk),
    .rst                (rst),
    .hash_readyxSI      (ready[0]),
    .hash_digestxSI     (dbit[0]),
    .digest_ackxSI      (ack[0]),
`ifdef HASH_DIGEST_CHECK_EN
    .expected_digestxSI (expd[0]),
    .matchxSO           (match[0]),
`endif
    .digestxSO          (digest[0]),
    .digest_validxSO    (valid[0]),
    .busyxSO            (busy[0]),
    .errxSO             (err[0]),
    .bit_countxSO       (cnt[0])
  );

  hash_digest_collector #(.L(L), .LAT(2), .CW(CW)) u_lat2 (
    .clk                (clk),
    .rst                (rst),
    .hash_readyxSI      (ready[1]),
    .hash_digestxSI     (dbit[1]),
    .digest_ackxSI      (ack[1]),
`ifdef HASH_DIGEST_CHECK_EN
    .expected_digestxSI (expd[1]),
    .matchxSO           (match[1]),
`endif
    .digestxSO          (digest[1]),
    .digest_validxSO    (valid[1]),
    .busyxSO            (busy[1]),
    .errxSO             (err[1]),
    .bit_countxSO       (cnt[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input int d, input string tag);
    chk({tag, "_digest"}, 32'(digest[d]), 32'd0);
    chk({tag, "_valid"},  32'(valid[d]),  32'd0);
    chk({tag, "_busy"},   32'(busy[d]),   32'd0);
    chk({tag, "_err"},    32'(err[d]),    32'd0);
    chk({tag, "_cnt"},    32'(cnt[d]),    32'd0);
`ifdef HASH_DIGEST_CHECK_EN
    chk({tag, "_match"},  32'(match[d]),  32'd0);
`endif
  endtask

  // One stream from IDLE: ready rises, LAT junk bits, then data LSB first.
  // drop < L truncates the stream by lowering ready instead of sending bit drop.
  task automatic capture(input int d, input logic [L-1:0] data, input int drop,
                         input logic flip);
    int lat;
    lat = (d == 0) ? 0 : 2;
`ifdef HASH_DIGEST_CHECK_EN
    expd[d] = flip ? (data ^ (L'(1) << ($urandom % L))) : data;
`endif
    ready[d] = 1'b1;
    dbit[d]  = 1'($urandom);
    tick();
    chk("start_busy", 32'(busy[d]), 32'd1);
    chk("start_err",  32'(err[d]),  32'd0);
    chk("start_cnt",  32'(cnt[d]),  32'd0);
`ifdef HASH_DIGEST_CHECK_EN
    chk("start_match", 32'(match[d]), 32'd0);
`endif
    for (int k = 0; k < lat; k++) begin
      dbit[d] = 1'b1;
      tick();
      chk("align_busy", 32'(busy[d]), 32'd1);
      chk("align_cnt",  32'(cnt[d]),  32'd0);
    end
    for (int i = 0; i < L; i++) begin
      ack[d] = 1'($urandom);
      if (i == drop) begin
        ready[d] = 1'b0;
        dbit[d]  = 1'($urandom);
        tick();
        ack[d] = 1'b0;
        chk("trunc_err",    32'(err[d]),    32'd1);
        chk("trunc_valid",  32'(valid[d]),  32'd0);
        chk("trunc_busy",   32'(busy[d]),   32'd0);
        chk("trunc_cnt",    32'(cnt[d]),    32'(drop));
        chk("trunc_digest", 32'(digest[d]), 32'(exp_dig[d]));
        return;
      end
      dbit[d] = data[i];
      tick();
      exp_dig[d][i] = data[i];
      chk("shift_cnt",   32'(cnt[d]),   32'(i + 1));
      chk("shift_valid", 32'(valid[d]), (i == L - 1) ? 32'd1 : 32'd0);
    end
    ack[d] = 1'b0;
    chk("done_digest", 32'(digest[d]), 32'(exp_dig[d]));
    chk("done_err",    32'(err[d]),    32'd0);
    chk("done_busy",   32'(busy[d]),   32'd0);
`ifdef HASH_DIGEST_CHECK_EN
    chk("done_match",  32'(match[d]),  flip ? 32'd0 : 32'd1);
`endif
  endtask

  // Hold the result while the serial line keeps toggling.
  task automatic hold(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      dbit[d] = 1'($urandom);
      tick();
      chk("hold_digest", 32'(digest[d]), 32'(exp_dig[d]));
      chk("hold_valid",  32'(valid[d]),  32'd1);
      chk("hold_cnt",    32'(cnt[d]),    32'(L));
    end
  endtask

  // mode 0: ack with ready high, then ready low later.
  // mode 1: ack and ready low together (straight to IDLE).
  // mode 2: ready low first (not an error), ack afterwards.
  // The following capture() confirms the block is back in IDLE.
  task automatic release_hold(input int d, input int mode);
    case (mode)
      0: begin
        ack[d] = 1'b1;
        tick();
        ack[d] = 1'b0;
        chk("ack_valid", 32'(valid[d]), 32'd0);
        chk("ack_busy",  32'(busy[d]),  32'd0);
        for (int i = 0; i < 2; i++) begin
          tick();
          chk("wait_busy",   32'(busy[d]),   32'd0);
          chk("wait_cnt",    32'(cnt[d]),    32'(L));
          chk("wait_digest", 32'(digest[d]), 32'(exp_dig[d]));
        end
        ready[d] = 1'b0;
        tick();
        chk("low_busy", 32'(busy[d]), 32'd0);
      end
      1: begin
        ack[d]   = 1'b1;
        ready[d] = 1'b0;
        tick();
        ack[d] = 1'b0;
        chk("both_valid", 32'(valid[d]), 32'd0);
      end
      default: begin
        ready[d] = 1'b0;
        tick();
        tick();
        chk("rdylow_valid", 32'(valid[d]), 32'd1);
        chk("rdylow_err",   32'(err[d]),   32'd0);
        ack[d] = 1'b1;
        tick();
        ack[d] = 1'b0;
        chk("late_ack_valid", 32'(valid[d]), 32'd0);
      end
    endcase
  endtask

  // Watchdog: the sequence below is bounded, this only guards against a hang.
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      ready[d] = 1'b0; dbit[d] = 1'b0; ack[d] = 1'b0; exp_dig[d] = '0;
`ifdef HASH_DIGEST_CHECK_EN
      expd[d] = '0;
`endif
    end
    tick();
    tick();
    chk_all_zero(0, "rst0");
    chk_all_zero(1, "rst1");
    rst = 1'b0;
    tick();

    // Directed 0xA5 on LAT=0, hold, ack with ready high, drop ready.
    capture(0, 8'hA5, L, 1'b0);
    chk("a5_digest", 32'(digest[0]), 32'hA5);
    chk("a5_cnt",    32'(cnt[0]),    32'd8);
    hold(0, 5);
    release_hold(0, 0);

    // Truncation after 3 bits, then a fresh start clears the error.
    capture(0, 8'h3C, 3, 1'b0);
    capture(0, 8'h5A, L, 1'b0);
    release_hold(0, 1);

    // LAT=2 with junk 1,1 ahead of 0xA5.
    capture(1, 8'hA5, L, 1'b0);
    chk("lat2_digest", 32'(digest[1]), 32'hA5);
    release_hold(1, 2);

    // Ready lost during ALIGN.
    ready[1] = 1'b1;
    tick();
    chk("abort_busy", 32'(busy[1]), 32'd1);
    ready[1] = 1'b0;
    tick();
    chk("abort_err",    32'(err[1]),    32'd1);
    chk("abort_busy2",  32'(busy[1]),   32'd0);
    chk("abort_cnt",    32'(cnt[1]),    32'd0);
    chk("abort_digest", 32'(digest[1]), 32'(exp_dig[1]));

    // Asynchronous reset pulse in the middle of a stream.
    ready[0] = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      dbit[0] = 1'b1;
      tick();
    end
    #2;
    rst = 1'b1;
    #0.5;
    chk_all_zero(0, "arst0");
    chk_all_zero(1, "arst1");
    #0.5;
    rst = 1'b0;
    ready[0] = 1'b0; dbit[0] = 1'b0;
    exp_dig[0] = '0; exp_dig[1] = '0;
    tick();
    capture(0, 8'hA5, L, 1'b0);
    chk("rerun_digest", 32'(digest[0]), 32'hA5);
    release_hold(0, 0);

    // Randomised streams on both instances.
    for (int n = 0; n < 40; n++) begin
      int d;
      int drop;
      logic [L-1:0] data;
      d    = int'($urandom % 2);
      data = L'($urandom);
      drop = (($urandom % 4) == 0) ? int'($urandom % L) : L;
      capture(d, data, drop, 1'($urandom));
      if (drop == L) begin
        hold(d, int'($urandom % 4));
        release_hold(d, int'($urandom % 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
